// File: rtl/life_engine.sv
// life_engine: streaming Game-of-Life stepper, one cell in per cycle, packed next-generation words out.
// Optional macro LIFE_POP_COUNT_EN adds the population output and its live-cell counter.
`default_nettype none

module life_engine #(
  parameter int         H_CELLS      = 800,
  parameter int         V_CELLS      = 600,
  parameter int         PACK         = 8,
  parameter logic [8:0] RULE_BIRTH   = 9'b000001000,
  parameter logic [8:0] RULE_SURVIVE = 9'b000001100
) (
  input  logic                                       clk_pixel,
  input  logic                                       rst_n,
  input  logic                                       cell_valid,
  input  logic                                       cell_in,
  input  logic                                       sof,
  output logic                                       in_ready,
  output logic                                       out_valid,
  output logic [PACK-1:0]                            out_data,
  output logic [$clog2(H_CELLS*V_CELLS/PACK)-1:0]    out_addr,
  output logic                                       frame_done,
  output logic [15:0]                                generation
`ifdef LIFE_POP_COUNT_EN
  ,
  output logic [19:0]                                population
`endif
);

  localparam int N_CELLS = H_CELLS * V_CELLS;
  localparam int AW      = $clog2(N_CELLS / PACK);
  localparam int IW      = $clog2(N_CELLS + 1);
  localparam int XW      = $clog2(H_CELLS + 2);
  localparam int YW      = $clog2(V_CELLS);
  localparam int BW      = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int SR_LEN  = 2 * H_CELLS + 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [XW-1:0]     ox_q, ox_d, fcnt_q, fcnt_d;
  logic [YW-1:0]     oy_q, oy_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [AW-1:0]     waddr_q, waddr_d;
  logic              s1_v_q, s1_bit_q, s1_last_q;
  logic [AW-1:0]     s1_addr_q;
  logic [PACK-1:0]   acc_q;
  logic              out_valid_q;
  logic [PACK-1:0]   out_data_q;
  logic [AW-1:0]     out_addr_q;
  logic [15:0]       gen_q;
  logic [SR_LEN-1:0] sr_q;

  logic              accept, start, emit_v, emit_bit, ring, centre, next_cell, word_last;
  logic [7:0]        nb;
  logic [3:0]        nb_cnt;
  logic [PACK:0]     word_ext;

  assign accept   = cell_valid && in_ready;
  assign in_ready = (state_q == S_IDLE) || (state_q == S_FILL) || (state_q == S_RUN);

  // sr_q[k] holds the cell accepted k+1 cycles-of-acceptance ago; the newest cell is the
  // bottom-right neighbour of the cell being finalised, which sits H_CELLS+1 back.
  always_ff @(posedge clk_pixel) begin
    if (accept) sr_q <= {sr_q[SR_LEN-2:0], cell_in};
  end

  assign nb = {sr_q[2*H_CELLS+1], sr_q[2*H_CELLS], sr_q[2*H_CELLS-1],
               sr_q[H_CELLS+1],                     sr_q[H_CELLS-1],
               sr_q[1],           sr_q[0],          cell_in};
  assign centre = sr_q[H_CELLS];

  always_comb begin
    nb_cnt = 4'd0;
    for (int k = 0; k < 8; k++) nb_cnt = nb_cnt + {3'b000, nb[k]};
  end

  assign next_cell = centre ? RULE_SURVIVE[nb_cnt] : RULE_BIRTH[nb_cnt];
  assign ring      = (ox_q == '0) || (ox_q == XW'(H_CELLS-1)) ||
                     (oy_q == '0) || (oy_q == YW'(V_CELLS-1));
  assign word_last = (bcnt_q == BW'(PACK-1));
  assign word_ext  = {acc_q, s1_bit_q};

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    fcnt_d   = fcnt_q;
    start    = 1'b0;
    emit_v   = 1'b0;
    emit_bit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept && sof) begin
          state_d = S_FILL;
          idx_d   = IW'(1);
          start   = 1'b1;
        end
      end
      S_FILL, S_RUN: begin
        if (accept) begin
          if (sof) begin
            state_d = S_FILL;
            idx_d   = IW'(1);
            start   = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
            if (state_q == S_RUN) begin
              emit_v   = 1'b1;
              emit_bit = ~ring & next_cell;
            end
            if (idx_q == IW'(H_CELLS)) state_d = S_RUN;
            if (idx_q == IW'(N_CELLS-1)) begin
              state_d = S_FLUSH;
              fcnt_d  = '0;
            end
          end
        end
      end
      S_FLUSH: begin
        // H_CELLS+1 zero ring cells, then one extra cycle lets the last word leave stage 1.
        fcnt_d = fcnt_q + 1'b1;
        if (fcnt_q <= XW'(H_CELLS)) emit_v = 1'b1;
        if (fcnt_q == XW'(H_CELLS+1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ox_d    = ox_q;
    oy_d    = oy_q;
    bcnt_d  = bcnt_q;
    waddr_d = waddr_q;
    if (start) begin
      ox_d    = '0;
      oy_d    = '0;
      bcnt_d  = '0;
      waddr_d = '0;
    end else if (emit_v) begin
      if (ox_q == XW'(H_CELLS-1)) begin
        ox_d = '0;
        oy_d = oy_q + 1'b1;
      end else begin
        ox_d = ox_q + 1'b1;
      end
      if (word_last) begin
        bcnt_d  = '0;
        waddr_d = waddr_q + 1'b1;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      fcnt_q      <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      bcnt_q      <= '0;
      waddr_q     <= '0;
      s1_v_q      <= 1'b0;
      s1_bit_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_addr_q   <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      gen_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      fcnt_q      <= fcnt_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      bcnt_q      <= bcnt_d;
      waddr_q     <= waddr_d;
      s1_v_q      <= emit_v;
      s1_bit_q    <= emit_bit;
      s1_last_q   <= word_last;
      s1_addr_q   <= waddr_q;
      out_valid_q <= 1'b0;
      // A restart drops any partially packed word so nothing of the old frame escapes.
      if (start) begin
        acc_q <= '0;
      end else if (s1_v_q) begin
        if (s1_last_q) begin
          out_valid_q <= 1'b1;
          out_data_q  <= word_ext[PACK-1:0];
          out_addr_q  <= s1_addr_q;
          acc_q       <= '0;
        end else begin
          acc_q <= word_ext[PACK-1:0];
        end
      end
      if (state_q == S_FLUSH && state_d == S_DONE) gen_q <= gen_q + 1'b1;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_addr   = out_addr_q;
  assign frame_done = (state_q == S_DONE);
  assign generation = gen_q;

`ifdef LIFE_POP_COUNT_EN
  logic [19:0] pop_acc_q, pop_q;

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      pop_acc_q <= '0;
      pop_q     <= '0;
    end else begin
      if (start)               pop_acc_q <= '0;
      else if (emit_v)         pop_acc_q <= pop_acc_q + {19'd0, emit_bit};
      if (state_q == S_FLUSH && state_d == S_DONE) pop_q <= pop_acc_q;
    end
  end

  assign population = pop_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_life_engine.sv
// tb_life_engine: scoreboard bench for life_engine on a 16x8 grid, default rule plus a HighLife instance.
`default_nettype none

module tb_life_engine;
  localparam int H  = 16;
  localparam int V  = 8;
  localparam int P  = 8;
  localparam int N  = H * V;
  localparam int NW = N / P;
  localparam int AWT = $clog2(NW);
  localparam logic [8:0] SURV     = 9'b000001100;
  localparam logic [8:0] BIRTH    = 9'b000001000;
  localparam logic [8:0] HL_BIRTH = 9'b001001000;

  logic clk = 1'b0, rst_n = 1'b0, cell_valid = 1'b0, cell_in = 1'b0, sof = 1'b0;
  logic in_ready, out_valid, frame_done;
  logic [P-1:0] out_data;
  logic [AWT-1:0] out_addr;
  logic [15:0] generation;
  logic hl_in_ready, hl_out_valid, hl_frame_done;
  logic [P-1:0] hl_out_data;
  logic [AWT-1:0] hl_out_addr;
  logic [15:0] hl_generation;
`ifdef LIFE_POP_COUNT_EN
  logic [19:0] population, hl_population;
`endif

  life_engine #(.H_CELLS(H), .V_CELLS(V), .PACK(P)) dut (
    .clk_pixel(clk), .rst_n(rst_n), .cell_valid(cell_valid), .cell_in(cell_in), .sof(sof),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_addr(out_addr),
    .frame_done(frame_done), .generation(generation)
`ifdef LIFE_POP_COUNT_EN
    , .population(population)
`endif
  );

  life_engine #(.H_CELLS(H), .V_CELLS(V), .PACK(P), .RULE_BIRTH(HL_BIRTH)) dut_hl (
    .clk_pixel(clk), .rst_n(rst_n), .cell_valid(cell_valid), .cell_in(cell_in), .sof(sof),
    .in_ready(hl_in_ready), .out_valid(hl_out_valid), .out_data(hl_out_data), .out_addr(hl_out_addr),
    .frame_done(hl_frame_done), .generation(hl_generation)
`ifdef LIFE_POP_COUNT_EN
    , .population(hl_population)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AWT-1:0] addr;
    logic [P-1:0]   data;
    int             cyc;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0, n_fail = 0, cyc = 0, fd_cnt = 0, hl_fd = 0, ov_total = 0, exp_gen = 0, exp_pop = 0;
  logic frame [N];
  logic [P-1:0] exp_word [NW];
  logic [P-1:0] hl_exp [NW];
  logic [P-1:0] last_words [NW];
  logic [P-1:0] hl_words [NW];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every emitted word is popped against the expectation pushed when its last input was driven.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      ov_total++;
      last_words[out_addr] = out_data;
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_word: got addr %0d data %h, nothing expected", out_addr, out_data);
      end else begin
        e = sb.pop_front();
        if (out_addr !== e.addr || out_data !== e.data) begin
          n_fail++;
          $display("FAIL word: got addr %0d data %h, expected addr %0d data %h",
                   out_addr, out_data, e.addr, e.data);
        end
        if (e.cyc >= 0) begin
          n_chk++;
          if (cyc !== e.cyc + 2) begin
            n_fail++;
            $display("FAIL latency: word %0d at cycle %0d, expected %0d", e.addr, cyc, e.cyc + 2);
          end
        end
      end
    end
    if (rst_n && frame_done) fd_cnt++;
    if (rst_n && hl_out_valid) hl_words[hl_out_addr] = hl_out_data;
    if (rst_n && hl_frame_done) hl_fd++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_frame(input logic v);
    for (int i = 0; i < N; i++) frame[i] = v;
  endtask

  task automatic set_cell(input int x, input int y);
    frame[y*H + x] = 1'b1;
  endtask

  task automatic clear_captures();
    for (int k = 0; k < NW; k++) begin
      last_words[k] = 8'hAA;
      hl_words[k]   = 8'hAA;
    end
  endtask

  // Reference: 2-D neighbourhood with a forced-dead outer ring.
  task automatic compute_model(input logic [8:0] birth);
    int n, idx;
    logic nv;
    exp_pop = 0;
    for (int k = 0; k < NW; k++) exp_word[k] = '0;
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        nv = 1'b0;
        if (!(x == 0 || x == H-1 || y == 0 || y == V-1)) begin
          n = 0;
          for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
              if (dx != 0 || dy != 0) n += int'(frame[(y+dy)*H + x + dx]);
          nv = frame[y*H + x] ? SURV[n] : birth[n];
        end
        idx = y*H + x;
        exp_word[idx/P][P-1-(idx%P)] = nv;
        exp_pop += int'(nv);
      end
    end
  endtask

  task automatic push_for(input int i);
    exp_t e;
    int c;
    c = i - H - 1;
    if (i >= H+1 && (c % P) == P-1) begin
      e.addr = AWT'(c/P); e.data = exp_word[c/P]; e.cyc = cyc;
      sb.push_back(e);
    end
    if (i == N-1) begin
      for (int k = 0; k < NW; k++) begin
        if (k*P + P-1 > N-H-2) begin
          e.addr = AWT'(k); e.data = exp_word[k]; e.cyc = -1;
          sb.push_back(e);
        end
      end
    end
  endtask

  task automatic send_frame(input int gap_pct, input int stop_at);
    int i, budget;
    i = 0; budget = 0;
    while (i < stop_at) begin
      @(negedge clk);
      budget++;
      if (budget > 20*N) begin
        n_chk++; n_fail++;
        $display("FAIL input_stall: only %0d of %0d cells accepted", i, stop_at);
        break;
      end
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        cell_valid = 1'b0; sof = 1'b0;
      end else begin
        cell_valid = 1'b1; cell_in = frame[i]; sof = (i == 0);
        if (in_ready) begin
          push_for(i);
          i++;
        end
      end
    end
    if (stop_at == N) begin
      @(negedge clk);
      cell_valid = 1'b0; sof = 1'b0;
    end
  endtask

  task automatic wait_frame(input int fd0);
    int t;
    t = 0;
    while (fd_cnt == fd0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_chk++; if (out_data !== '0)    begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_chk++; if (out_addr !== '0)    begin n_fail++; $display("FAIL reset_out_addr: got %0d want 0", out_addr); end
    n_chk++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    n_chk++; if (generation !== 16'd0) begin n_fail++; $display("FAIL reset_generation: got %0d want 0", generation); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_blinker();
    int fd0;
    clear_frame(1'b0); clear_captures();
    set_cell(5, 2); set_cell(5, 3); set_cell(5, 4);
    compute_model(BIRTH);
    fd0 = fd_cnt; exp_gen++;
    send_frame(0, N);
    wait_frame(fd0);
    n_chk++; if (fd_cnt !== fd0 + 1) begin n_fail++; $display("FAIL blinker_frame_done: got %0d pulses want 1", fd_cnt - fd0); end
    n_chk++; if (sb.size() !== 0) begin n_fail++; $display("FAIL blinker_words: %0d words missing want 0", sb.size()); end
    n_chk++; if (last_words[6] !== 8'h0E) begin n_fail++; $display("FAIL blinker_word6: got %h want 0e", last_words[6]); end
    n_chk++; if (generation !== 16'(exp_gen)) begin n_fail++; $display("FAIL blinker_generation: got %0d want %0d", generation, exp_gen); end
`ifdef LIFE_POP_COUNT_EN
    n_chk++; if (population !== 20'd3) begin n_fail++; $display("FAIL blinker_population: got %0d want 3", population); end
`endif
  endtask

  task automatic test_block();
    int fd0;
    clear_frame(1'b0); clear_captures();
    set_cell(7, 3); set_cell(8, 3); set_cell(7, 4); set_cell(8, 4);
    compute_model(BIRTH);
    fd0 = fd_cnt; exp_gen++;
    send_frame(0, N);
    wait_frame(fd0);
    n_chk++; if (fd_cnt !== fd0 + 1) begin n_fail++; $display("FAIL block_frame_done: got %0d pulses want 1", fd_cnt - fd0); end
    n_chk++; if (sb.size() !== 0) begin n_fail++; $display("FAIL block_words: %0d words missing want 0", sb.size()); end
    n_chk++; if (last_words[6] !== 8'h01 || last_words[9] !== 8'h80) begin
      n_fail++; $display("FAIL block_cells: got w6 %h w9 %h want 01 80", last_words[6], last_words[9]);
    end
    n_chk++; if (generation !== 16'(exp_gen)) begin n_fail++; $display("FAIL block_generation: got %0d want %0d", generation, exp_gen); end
`ifdef LIFE_POP_COUNT_EN
    n_chk++; if (population !== 20'd4) begin n_fail++; $display("FAIL block_population: got %0d want 4", population); end
`endif
  endtask

  task automatic test_all_live();
    int fd0;
    clear_frame(1'b1); clear_captures();
    compute_model(BIRTH);
    fd0 = fd_cnt; exp_gen++;
    send_frame(0, N);
    wait_frame(fd0);
    n_chk++; if (sb.size() !== 0) begin n_fail++; $display("FAIL all_live_words: %0d words missing want 0", sb.size()); end
    n_chk++; if (last_words[0] !== 8'h00 || last_words[1] !== 8'h00 || last_words[14] !== 8'h00 || last_words[15] !== 8'h00) begin
      n_fail++; $display("FAIL all_live_ring_rows: got %h %h %h %h want 00",
                         last_words[0], last_words[1], last_words[14], last_words[15]);
    end
    for (int y = 1; y < V-1; y++) begin
      n_chk++;
      if (last_words[2*y][P-1] !== 1'b0 || last_words[2*y+1][0] !== 1'b0) begin
        n_fail++; $display("FAIL all_live_side_ring: row %0d got left %b right %b want 0 0",
                           y, last_words[2*y][P-1], last_words[2*y+1][0]);
      end
    end
  endtask

  task automatic test_gaps();
    int fd0;
    for (int i = 0; i < N; i++) frame[i] = 1'($urandom_range(1));
    clear_captures();
    compute_model(BIRTH);
    fd0 = fd_cnt; exp_gen++;
    send_frame(35, N);
    wait_frame(fd0);
    n_chk++; if (sb.size() !== 0) begin n_fail++; $display("FAIL gaps_words: %0d words missing want 0", sb.size()); end
    n_chk++; if (generation !== 16'(exp_gen)) begin n_fail++; $display("FAIL gaps_generation: got %0d want %0d", generation, exp_gen); end
  endtask

  task automatic test_highlife();
    int fd0, hfd0;
    clear_frame(1'b0); clear_captures();
    set_cell(7, 3); set_cell(8, 3); set_cell(9, 3);
    set_cell(7, 5); set_cell(8, 5); set_cell(9, 5);
    compute_model(HL_BIRTH);
    for (int k = 0; k < NW; k++) hl_exp[k] = exp_word[k];
    compute_model(BIRTH);
    fd0 = fd_cnt; hfd0 = hl_fd; exp_gen++;
    send_frame(0, N);
    wait_frame(fd0);
    n_chk++; if (hl_fd !== hfd0 + 1) begin n_fail++; $display("FAIL highlife_frame_done: got %0d pulses want 1", hl_fd - hfd0); end
    n_chk++; if (hl_words[9][P-1] !== 1'b1) begin n_fail++; $display("FAIL highlife_birth: got %b want 1", hl_words[9][P-1]); end
    n_chk++; if (last_words[9][P-1] !== 1'b0) begin n_fail++; $display("FAIL default_no_birth6: got %b want 0", last_words[9][P-1]); end
    for (int k = 0; k < NW; k++) begin
      n_chk++;
      if (hl_words[k] !== hl_exp[k]) begin
        n_fail++; $display("FAIL highlife_word: word %0d got %h want %h", k, hl_words[k], hl_exp[k]);
      end
    end
  endtask

  task automatic test_abort();
    int fd0;
    clear_frame(1'b0); clear_captures();
    set_cell(5, 2); set_cell(5, 3); set_cell(5, 4);
    compute_model(BIRTH);
    fd0 = fd_cnt; exp_gen++;
    send_frame(0, 40);
    clear_frame(1'b0);
    set_cell(7, 3); set_cell(8, 3); set_cell(7, 4); set_cell(8, 4);
    compute_model(BIRTH);
    send_frame(0, N);
    wait_frame(fd0);
    n_chk++; if (fd_cnt !== fd0 + 1) begin n_fail++; $display("FAIL abort_frame_done: got %0d pulses want 1", fd_cnt - fd0); end
    n_chk++; if (sb.size() !== 0) begin n_fail++; $display("FAIL abort_words: %0d words missing want 0", sb.size()); end
    n_chk++; if (generation !== 16'(exp_gen)) begin n_fail++; $display("FAIL abort_generation: got %0d want %0d", generation, exp_gen); end
    n_chk++; if (last_words[6] !== 8'h01) begin n_fail++; $display("FAIL abort_new_frame: got w6 %h want 01", last_words[6]); end
  endtask

  task automatic test_reset_mid();
    int fd0, ov0;
    for (int i = 0; i < N; i++) frame[i] = 1'($urandom_range(1));
    clear_captures();
    compute_model(BIRTH);
    send_frame(0, 70);
    @(negedge clk);
    rst_n = 1'b0; cell_valid = 1'b0; sof = 1'b0;
    sb.delete();
    #1;
    n_chk++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL midreset_ctrl: got in_ready %b out_valid %b frame_done %b want 1 0 0", in_ready, out_valid, frame_done);
    end
    n_chk++; if (out_data !== '0 || out_addr !== '0) begin
      n_fail++; $display("FAIL midreset_data: got data %h addr %0d want 0 0", out_data, out_addr);
    end
    n_chk++; if (generation !== 16'd0) begin n_fail++; $display("FAIL midreset_generation: got %0d want 0", generation); end
`ifdef LIFE_POP_COUNT_EN
    n_chk++; if (population !== 20'd0) begin n_fail++; $display("FAIL midreset_population: got %0d want 0", population); end
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_gen = 0;
    fd0 = fd_cnt; ov0 = ov_total;
    for (int i = 0; i < 3*H; i++) begin
      @(negedge clk);
      cell_valid = 1'b1; cell_in = frame[i]; sof = 1'b0;
    end
    @(negedge clk);
    cell_valid = 1'b0;
    repeat (2*H) @(negedge clk);
    n_chk++; if (ov_total !== ov0 || fd_cnt !== fd0) begin
      n_fail++; $display("FAIL nosof_ignored: got %0d words %0d frames want 0 0", ov_total - ov0, fd_cnt - fd0);
    end
    fd0 = fd_cnt; exp_gen++;
    send_frame(0, N);
    wait_frame(fd0);
    n_chk++; if (sb.size() !== 0) begin n_fail++; $display("FAIL postreset_words: %0d words missing want 0", sb.size()); end
    n_chk++; if (generation !== 16'(exp_gen)) begin n_fail++; $display("FAIL postreset_generation: got %0d want %0d", generation, exp_gen); end
  endtask

  initial begin
    test_reset();
    test_blinker();
    test_block();
    test_all_live();
    test_gaps();
    test_highlife();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/life_engine.md
LIFE_ENGINE -- requirements
Module: life_engine

Interface
REQ-001 SHALL provide parameter H_CELLS, default 800, grid width in cells (>=4).
REQ-002 SHALL provide parameter V_CELLS, default 600, grid height in cells (>=3).
REQ-003 SHALL provide parameter PACK, default 8, cells per output word; H_CELLS*V_CELLS SHALL be a multiple of PACK.
REQ-004 SHALL provide parameter RULE_BIRTH, default 9'b000001000, bit n set = dead cell with n live neighbours is born.
REQ-005 SHALL provide parameter RULE_SURVIVE, default 9'b000001100, bit n set = live cell with n live neighbours survives.
REQ-006 clk_pixel  input  1  sole clock, all state on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 cell_valid  input  1  cell_in valid this cycle; accepted when cell_valid && in_ready.
REQ-009 cell_in  input  1  current-generation cell, raster order, 1 = live.
REQ-010 sof  input  1  qualifies accepted cell as index 0 of a frame.
REQ-011 in_ready  output  1  engine accepts a cell this cycle.
REQ-012 out_valid  output  1  one-cycle strobe, out_data/out_addr valid.
REQ-013 out_data  output  PACK  next-generation cells, MSB = lowest cell index.
REQ-014 out_addr  output  clog2(H_CELLS*V_CELLS/PACK)  word index, 0 = top-left.
REQ-015 frame_done  output  1  one-cycle pulse, frame fully emitted.
REQ-016 generation  output  16  completed-frame count.
REQ-017 population  output  20  live cells in last completed output frame (LIFE_POP_COUNT_EN only).

Function
REQ-018 SHALL hold two H_CELLS-deep line buffers plus 3x3 window; neighbour count 0..8, 4-bit.
REQ-019 next cell = alive ? RULE_SURVIVE[n] : RULE_BIRTH[n].
REQ-020 Outermost ring (x=0, x=H_CELLS-1, y=0, y=V_CELLS-1) SHALL be output as 0; no wrap between left/right edges or top/bottom.
REQ-021 States: IDLE, FILL, RUN, FLUSH, DONE.
REQ-022 IDLE: in_ready=1; accepted cell with sof -> FILL as index 0; accepted cell without sof discarded.
REQ-023 FILL: accept indices 1..H_CELLS; no output; after index H_CELLS -> RUN.
REQ-024 RUN: acceptance of input index i (i>=H_CELLS+1) SHALL finalise output cell i-H_CELLS-1.
REQ-025 Word k SHALL appear with out_valid exactly 2 cycles after acceptance of the input cell finalising its last cell; out_addr = k.
REQ-026 After input index H_CELLS*V_CELLS-1 -> FLUSH: in_ready=0, remaining H_CELLS+1 cells (all ring) emitted one cell per cycle, zero.
REQ-027 FLUSH complete -> DONE for one cycle: frame_done=1, generation += 1 (wraps 16'hFFFF -> 0), -> IDLE.
REQ-028 Gaps in cell_valid SHALL stall the pipeline without changing output values.
REQ-029 sof on an accepted cell in FILL/RUN SHALL abort the frame: restart as index 0, no out_valid for the aborted frame after abort, generation unchanged.
REQ-030 cell_valid during FLUSH/DONE ignored.

Reset
REQ-031 rst_n low: state IDLE, in_ready=1, out_valid=0, out_data=0, out_addr=0, frame_done=0, generation=0, population=0, window and line buffers need not clear.
REQ-032 Reset mid-frame SHALL discard the frame; first frame after release needs sof.

Configuration
REQ-033 Macro LIFE_POP_COUNT_EN defined: population port present; running count of emitted live cells loaded into population in DONE cycle, accumulator cleared on sof.
REQ-034 LIFE_POP_COUNT_EN undefined: population port and counter absent; all else identical.

Verification
REQ-035 H=16,V=8,PACK=8, default rule, vertical blinker at (5,2..4) -> output horizontal blinker (4..6,3): word 6 = 8'h0E, all others 0, frame_done once, generation=1.
REQ-036 Same grid, 2x2 block at (7..8,3..4) -> identical block out; population=4 with macro.
REQ-037 All-live input -> ring words zero (words 0,1,14,15 = 0), interior left/right bits 0.
REQ-038 RULE_BIRTH=9'b001001000 (HighLife), single dead cell with 6 live neighbours -> born.
REQ-039 sof reasserted at index 40 -> aborted frame emits nothing further, new frame completes, generation increments once.
REQ-040 rst_n low at index 70 -> all outputs reset values, generation=0, cells without sof ignored.
